m2s_request_arbiter: RTL and testbench

- Shares the single request FIFO toward the multi2sim VPI interface among NUM_REQ independent requesters.
- Allocates a unique 10-bit transaction ID per granted request and records which requester owns it.
- Drains the serve FIFO and routes each response back to the owning requester by ID, then frees that ID.
- Sits between the requester ports and the two_piped_fifos request/serve ports.

---
 rtl/m2s_pkg.sv | 38 +++
 rtl/m2s_request_arbiter_if.sv | 40 ++++
 rtl/m2s_id_pool.sv | 72 +++++++
 rtl/m2s_request_arbiter.sv | 143 ++++++++++++++
 tb/tb_m2s_request_arbiter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/m2s_pkg.sv
// Shared definitions for the multi2sim request arbiter: field widths,
// request/serve word layouts and the response FSM state type.
package m2s_pkg;

  localparam int ID_W   = 10;
  localparam int REQ_W  = 64;
  localparam int SRV_W  = 52;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 11;

  // Request word: {rw_flag, address[30:0], data[31:0]}
  localparam int REQ_DATA_LSB = 0;
  localparam int REQ_ADDR_LSB = 32;
  localparam int REQ_RW_BIT   = 63;

  // Serve word: {data[31:0], id[9:0], next_id[9:0]}
  localparam int SRV_NEXT_ID_LSB = 0;
  localparam int SRV_ID_LSB      = 10;
  localparam int SRV_DATA_LSB    = 20;

  typedef struct packed {
    logic        rw;
    logic [30:0] addr;
    logic [31:0] data;
  } req_word_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
    logic [ID_W-1:0]   next_id;
  } srv_word_t;

  typedef enum logic {
    S_IDLE,
    S_DELIVER
  } rsp_state_t;

endpackage

// File: rtl/m2s_request_arbiter_if.sv
// Requester, request-FIFO and serve-FIFO signals of the arbiter, bundled.
// master is the arbiter's view; slave is the surrounding environment's view.
interface m2s_request_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = 64
);
    import m2s_pkg::ID_W;
    import m2s_pkg::SRV_W;
    import m2s_pkg::DATA_W;
    import m2s_pkg::CNT_W;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*REQ_W-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [DATA_W-1:0]        rsp_data;
    logic [ID_W-1:0]          rsp_id;
    logic                     fifo_wr_en;
    logic [REQ_W-1:0]         fifo_wr_data;
    logic [ID_W-1:0]          fifo_wr_id;
    logic                     fifo_full;
    logic                     srv_rd_en;
    logic [SRV_W-1:0]         srv_data;
    logic                     srv_empty;
    logic [CNT_W-1:0]         outstanding;
    logic                     err_unknown_id;

    modport master (
        input  req_valid, req_data, fifo_full, srv_data, srv_empty,
        output req_ready, rsp_valid, rsp_data, rsp_id, fifo_wr_en, fifo_wr_data,
               fifo_wr_id, srv_rd_en, outstanding, err_unknown_id
    );

    modport slave (
        output req_valid, req_data, fifo_full, srv_data, srv_empty,
        input  req_ready, rsp_valid, rsp_data, rsp_id, fifo_wr_en, fifo_wr_data,
               fifo_wr_id, srv_rd_en, outstanding, err_unknown_id
    );

endinterface

// File: rtl/m2s_id_pool.sv
// Transaction ID pool: busy bitmap, lowest-free encoder, owner table and
// outstanding counter. Alloc and free may happen in the same cycle.
module m2s_id_pool
    import m2s_pkg::*;
#(
    parameter int MAX_OUT = 16,
    parameter int OWN_W   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_en,
    input  logic [OWN_W-1:0] alloc_owner,
    output logic             free_avail,
    output logic [ID_W-1:0]  alloc_id,
    input  logic             free_en,
    input  logic [ID_W-1:0]  query_id,
    output logic             query_hit,
    output logic [OWN_W-1:0] query_owner,
    output logic [CNT_W-1:0] outstanding
);

    logic [MAX_OUT-1:0] busy;
    logic [OWN_W-1:0]   owner [MAX_OUT];

    assign free_avail = ~&busy;

    // NOTE: every combinational output gets a default before the loop so no latch is inferred.
    always_comb begin
        alloc_id = '0;
        for (int i = MAX_OUT - 1; i >= 0; i--) begin
            if (!busy[i]) alloc_id = ID_W'(i);
        end
    end

    // Out-of-range IDs match no entry and therefore never hit.
    always_comb begin
        query_hit   = 1'b0;
        query_owner = '0;
        for (int i = 0; i < MAX_OUT; i++) begin
            if (query_id == ID_W'(i)) begin
                query_hit   = busy[i];
                query_owner = owner[i];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy        <= '0;
            outstanding <= '0;
        end else begin
            for (int i = 0; i < MAX_OUT; i++) begin
                if (alloc_en && alloc_id == ID_W'(i)) busy[i] <= 1'b1;
                if (free_en && query_id == ID_W'(i))  busy[i] <= 1'b0;
            end
            case ({alloc_en, free_en})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // NOTE: the owner table has no reset; an entry is only read while its busy bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_OUT; i++) begin
            if (alloc_en && alloc_id == ID_W'(i)) owner[i] <= alloc_owner;
        end
    end

endmodule

// File: rtl/m2s_request_arbiter.sv
// Round-robin arbiter sharing the multi2sim request FIFO among NUM_REQ
// requesters, with ID allocation and ID-routed response delivery.
module m2s_request_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MAX_OUT = 16,
    parameter int REQ_W   = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    m2s_request_arbiter_if.master bus
);
    import m2s_pkg::ID_W;
    import m2s_pkg::srv_word_t;
    import m2s_pkg::rsp_state_t;
    import m2s_pkg::S_IDLE;
    import m2s_pkg::S_DELIVER;

    localparam int OWN_W = $clog2(NUM_REQ);

    logic [OWN_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] valid_rot;
    logic               grant_hit;
    int                 grant_off;
    int                 grant_sum;
    logic [OWN_W-1:0]   grant_idx;
    logic [REQ_W-1:0]   grant_data;
    logic               do_grant;

    logic               free_avail;
    logic [ID_W-1:0]    alloc_id;
    logic               query_hit;
    logic [OWN_W-1:0]   query_owner;
    logic               free_en;
    logic               err_set;

    rsp_state_t         state, state_nxt;
    srv_word_t          srv_word;
    logic               unused_next_id;

    assign srv_word       = srv_word_t'(bus.srv_data);
    assign unused_next_id = ^srv_word.next_id;

    // Rotate valids so bit 0 is rr_ptr; the lowest set bit is the winner.
    always_comb begin
        valid_rot = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr);
        grant_hit = 1'b0;
        grant_off = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                grant_hit = 1'b1;
                grant_off = k;
            end
        end
        grant_sum = int'(rr_ptr) + grant_off;
        if (grant_sum >= NUM_REQ) grant_sum = grant_sum - NUM_REQ;
        grant_idx  = OWN_W'(grant_sum);
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == OWN_W'(i)) grant_data = bus.req_data[i*REQ_W +: REQ_W];
        end
        do_grant = !reset && grant_hit && !bus.fifo_full && free_avail;
    end

    always_comb begin
        bus.req_ready    = '0;
        bus.fifo_wr_en   = 1'b0;
        bus.fifo_wr_data = '0;
        bus.fifo_wr_id   = '0;
        if (do_grant) begin
            for (int i = 0; i < NUM_REQ; i++) bus.req_ready[i] = (grant_idx == OWN_W'(i));
            bus.fifo_wr_en   = 1'b1;
            bus.fifo_wr_data = grant_data;
            bus.fifo_wr_id   = alloc_id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (do_grant) begin
            rr_ptr <= (grant_sum == NUM_REQ - 1) ? '0 : OWN_W'(grant_sum + 1);
        end
    end

    m2s_id_pool #(
        .MAX_OUT (MAX_OUT),
        .OWN_W   (OWN_W)
    ) u_id_pool (
        .clk         (clk),
        .reset       (reset),
        .alloc_en    (do_grant),
        .alloc_owner (grant_idx),
        .free_avail  (free_avail),
        .alloc_id    (alloc_id),
        .free_en     (free_en),
        .query_id    (srv_word.id),
        .query_hit   (query_hit),
        .query_owner (query_owner),
        .outstanding (bus.outstanding)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Serve data is valid the cycle after the read, so one response per two cycles.
    always_comb begin
        state_nxt     = state;
        bus.srv_rd_en = 1'b0;
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        bus.rsp_id    = '0;
        free_en       = 1'b0;
        err_set       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!reset && !bus.srv_empty) begin
                    bus.srv_rd_en = 1'b1;
                    state_nxt     = S_DELIVER;
                end
            end
            S_DELIVER: begin
                state_nxt = S_IDLE;
                if (query_hit) begin
                    for (int i = 0; i < NUM_REQ; i++) bus.rsp_valid[i] = (query_owner == OWN_W'(i));
                    bus.rsp_data = srv_word.data;
                    bus.rsp_id   = srv_word.id;
                    free_en      = 1'b1;
                end else begin
                    err_set = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        bus.err_unknown_id <= 1'b0;
        else if (err_set) bus.err_unknown_id <= 1'b1;
    end

endmodule

// File: tb/tb_m2s_request_arbiter.sv
// Directed bench for m2s_request_arbiter: expected grants and responses are
// queued when stimulus is driven and compared when the DUT produces them.
module tb_m2s_request_arbiter;
    import m2s_pkg::*;

    localparam int NREQ = 4;
    localparam int MOUT = 16;

    typedef struct packed {
        logic [NREQ-1:0]  ready;
        logic [ID_W-1:0]  id;
        logic [REQ_W-1:0] data;
    } grant_t;

    typedef struct packed {
        logic [NREQ-1:0]   valid;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    grant_t grant_q[$];
    rsp_t   rsp_q[$];

    always #5 clk = ~clk;

    m2s_request_arbiter_if #(.NUM_REQ(NREQ), .REQ_W(REQ_W)) bus ();

    m2s_request_arbiter #(
        .NUM_REQ (NREQ),
        .MAX_OUT (MOUT),
        .REQ_W   (REQ_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic exp_grant(input logic [NREQ-1:0] r, input int id, input logic [REQ_W-1:0] d);
        grant_q.push_back('{ready: r, id: ID_W'(id), data: d});
    endtask

    task automatic exp_rsp(input logic [NREQ-1:0] v, input int id, input logic [DATA_W-1:0] d);
        rsp_q.push_back('{valid: v, id: ID_W'(id), data: d});
    endtask

    task automatic set_req(input int r, input logic [REQ_W-1:0] d);
        bus.req_data[r*REQ_W +: REQ_W] = d;
    endtask

    function automatic logic [REQ_W-1:0] rr_data(input int i);
        return 64'h4000_0100_A000_0000 + 64'(i);
    endfunction

    // Sample mid-cycle; pop the scoreboard on any DUT grant or response.
    task automatic settle_sample();
        grant_t g;
        rsp_t   r;
        #2;
        if (bus.fifo_wr_en) begin
            check("grant_expected", 64'(grant_q.size() != 0), 64'd1);
            if (grant_q.size() != 0) begin
                g = grant_q.pop_front();
                check("grant_ready", 64'(bus.req_ready), 64'(g.ready));
                check("grant_id", 64'(bus.fifo_wr_id), 64'(g.id));
                check("grant_data", bus.fifo_wr_data, g.data);
            end
        end
        if (bus.rsp_valid != '0) begin
            check("rsp_expected", 64'(rsp_q.size() != 0), 64'd1);
            if (rsp_q.size() != 0) begin
                r = rsp_q.pop_front();
                check("rsp_valid", 64'(bus.rsp_valid), 64'(r.valid));
                check("rsp_id", 64'(bus.rsp_id), 64'(r.id));
                check("rsp_data", 64'(bus.rsp_data), 64'(r.data));
            end
        end
        check("grant_sb_drained", 64'(grant_q.size()), 64'd0);
        check("rsp_sb_drained", 64'(rsp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        check("rst_fifo_wr_en", 64'(bus.fifo_wr_en), 64'd0);
        check("rst_srv_rd_en", 64'(bus.srv_rd_en), 64'd0);
        check("rst_outstanding", 64'(bus.outstanding), 64'd0);
        check("rst_err", 64'(bus.err_unknown_id), 64'd0);
        grant_q.delete();
        rsp_q.delete();
        cyc();
        reset = 1'b0;
    endtask

    // Present one serve word; returns at the drive point of the delivery cycle.
    task automatic serve_issue(input logic [DATA_W-1:0] d, input int id);
        bus.srv_data  = {d, ID_W'(id), ID_W'(0)};
        bus.srv_empty = 1'b0;
        settle_sample();
        check("srv_rd_en_pulse", 64'(bus.srv_rd_en), 64'd1);
        cyc();
        bus.srv_empty = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        bus.srv_data  = '0;
        bus.srv_empty = 1'b1;
        cyc();
        do_reset();

        // Single request from requester 1, then its response.
        bus.req_valid = 4'b0010;
        set_req(1, 64'h8000_0010_DEAD_BEEF);
        exp_grant(4'b0010, 0, 64'h8000_0010_DEAD_BEEF);
        settle_sample();
        check("single_wr_en", 64'(bus.fifo_wr_en), 64'd1);
        cyc();
        bus.req_valid = '0;
        settle_sample();
        check("single_outstanding", 64'(bus.outstanding), 64'd1);
        check("single_no_regrant", 64'(bus.fifo_wr_en), 64'd0);
        cyc();
        serve_issue(32'h1234_5678, 0);
        exp_rsp(4'b0010, 0, 32'h1234_5678);
        settle_sample();
        check("single_rd_en_drop", 64'(bus.srv_rd_en), 64'd0);
        check("single_rsp_valid", 64'(bus.rsp_valid), 64'h2);
        cyc();
        settle_sample();
        check("single_outstanding_back", 64'(bus.outstanding), 64'd0);
        check("single_rsp_pulse_end", 64'(bus.rsp_valid), 64'd0);
        cyc();

        // Round-robin with all four requesters valid.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, rr_data(i));
        bus.req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            exp_grant(NREQ'(1 << (k % NREQ)), k, rr_data(k % NREQ));
            settle_sample();
            check("rr_wr_en", 64'(bus.fifo_wr_en), 64'd1);
            cyc();
        end
        bus.req_valid = '0;
        settle_sample();
        check("rr_outstanding", 64'(bus.outstanding), 64'd8);
        cyc();

        // ID exhaustion, then return ID 5.
        do_reset();
        bus.req_valid = 4'b0001;
        set_req(0, 64'h0000_0001_CAFE_0000);
        for (int k = 0; k < MOUT; k++) begin
            exp_grant(4'b0001, k, 64'h0000_0001_CAFE_0000);
            settle_sample();
            cyc();
        end
        settle_sample();
        check("exh_ready", 64'(bus.req_ready), 64'd0);
        check("exh_wr_en", 64'(bus.fifo_wr_en), 64'd0);
        check("exh_outstanding", 64'(bus.outstanding), 64'd16);
        cyc();
        serve_issue(32'h5555_AAAA, 5);
        exp_rsp(4'b0001, 5, 32'h5555_AAAA);
        settle_sample();
        check("exh_free_not_visible", 64'(bus.req_ready), 64'd0);
        check("exh_outstanding_hold", 64'(bus.outstanding), 64'd16);
        cyc();
        exp_grant(4'b0001, 5, 64'h0000_0001_CAFE_0000);
        settle_sample();
        check("exh_outstanding_after_free", 64'(bus.outstanding), 64'd15);
        cyc();
        bus.req_valid = '0;
        settle_sample();
        check("exh_outstanding_refill", 64'(bus.outstanding), 64'd16);
        cyc();

        // FIFO full stalls grants; rr_ptr holds its place.
        do_reset();
        set_req(0, 64'h0000_0000_0000_00A0);
        set_req(1, 64'h0000_0000_0000_00A1);
        set_req(2, 64'h0000_0000_0000_00A2);
        bus.req_valid = 4'b0010;
        exp_grant(4'b0010, 0, 64'h0000_0000_0000_00A1);
        settle_sample();
        cyc();
        bus.req_valid = 4'b0101;
        bus.fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle_sample();
            check("full_wr_en", 64'(bus.fifo_wr_en), 64'd0);
            check("full_ready", 64'(bus.req_ready), 64'd0);
            cyc();
        end
        bus.fifo_full = 1'b0;
        exp_grant(4'b0100, 1, 64'h0000_0000_0000_00A2);
        settle_sample();
        cyc();
        exp_grant(4'b0001, 2, 64'h0000_0000_0000_00A0);
        settle_sample();
        cyc();
        bus.req_valid = '0;

        // Unknown IDs: out of range and not busy.
        do_reset();
        serve_issue(32'hBAD0_0014, 20);
        settle_sample();
        check("unk20_no_rsp", 64'(bus.rsp_valid), 64'd0);
        cyc();
        settle_sample();
        check("unk20_err", 64'(bus.err_unknown_id), 64'd1);
        serve_issue(32'hBAD0_0003, 3);
        settle_sample();
        check("unk3_no_rsp", 64'(bus.rsp_valid), 64'd0);
        cyc();
        for (int k = 0; k < 3; k++) begin
            settle_sample();
            check("unk_err_sticky", 64'(bus.err_unknown_id), 64'd1);
            cyc();
        end
        bus.req_valid = 4'b0001;
        exp_grant(4'b0001, 0, 64'h0000_0000_0000_00A0);
        settle_sample();
        cyc();
        bus.req_valid = '0;
        do_reset();
        serve_issue(32'h0000_0BAD, 0);
        settle_sample();
        check("prereset_no_rsp", 64'(bus.rsp_valid), 64'd0);
        cyc();
        settle_sample();
        check("prereset_err", 64'(bus.err_unknown_id), 64'd1);
        cyc();

        // Simultaneous allocate and free.
        do_reset();
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            exp_grant(4'b0001, k, 64'h0000_0000_0000_00A0);
            settle_sample();
            cyc();
        end
        bus.req_valid = '0;
        settle_sample();
        check("sim_outstanding_pre", 64'(bus.outstanding), 64'd3);
        cyc();
        serve_issue(32'hF00D_0000, 0);
        bus.req_valid = 4'b0010;
        exp_grant(4'b0010, 3, 64'h0000_0000_0000_00A1);
        exp_rsp(4'b0001, 0, 32'hF00D_0000);
        settle_sample();
        cyc();
        bus.req_valid = '0;
        settle_sample();
        check("sim_outstanding_same", 64'(bus.outstanding), 64'd3);
        cyc();
        bus.req_valid = 4'b0010;
        exp_grant(4'b0010, 0, 64'h0000_0000_0000_00A1);
        settle_sample();
        cyc();
        bus.req_valid = '0;
        settle_sample();
        check("sim_outstanding_post", 64'(bus.outstanding), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
